fft_power_collector: RTL and testbench
======================================

Name: fft_power_collector

Overview:
- Sink for the FFT_16kHz output stream (dv, xk_index, xk_re, xk_im).
- Squares and sums each bin to a scaled power value and stores the non-redundant half-spectrum (bins 0..N/2) in an internal single frame buffer.
- After a full frame has been captured, streams the bins in ascending order to the feature stage over a valid/ready handshake.

Parameters:
- NFFT_LOG2, 9, log2 of FFT length N (N=512).
- XK_W, 40, width of signed xk_re/xk_im.
- PWR_SHIFT, 30, right shift applied to re^2+im^2.
- PWR_W, 64, width of stored/output power.
- KEEP_BINS, 257, bins kept (indices 0..KEEP_BINS-1); must be <= N.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dv  in  1  FFT output data valid.
- xk_index  in  NFFT_LOG2  bin index of the current output.
- xk_re  in  XK_W  signed real part.
- xk_im  in  XK_W  signed imaginary part.
- ovf_clr  in  1  clears the sticky overrun flag.
- pwr_valid  out  1  output bin valid.
- pwr_ready  in  1  downstream accepts the bin.
- pwr_data  out  PWR_W  power of the bin.
- pwr_bin  out  NFFT_LOG2  index of the output bin.
- pwr_last  out  1  marks bin KEEP_BINS-1.
- busy  out  1  high in COLLECT or DRAIN.
- ovf  out  1  sticky: dv seen while in DRAIN.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; beat counter=0; pipeline cleared; pwr_valid=0, pwr_data=0, pwr_bin=0, pwr_last=0, busy=0, ovf=0. Buffer contents are undefined.
- States and transitions:
  - IDLE→COLLECT on the first dv.
  - COLLECT→DRAIN when the N-th dv beat has been written (pipeline empty).
  - DRAIN→IDLE on the handshake of the pwr_last beat.
- Power pipeline, 2 stages:
  - Stage 1 (cycle after dv): registers re*re and im*im, signed 2*XK_W bits each, plus index and valid.
  - Stage 2: sum at 2*XK_W+1 bits, arithmetic >> PWR_SHIFT, then write to buffer[index].
  - If the result exceeds PWR_W bits, saturate to all-ones. With the defaults this never occurs (51 significant bits).
  - dv at cycle t → buffer written at rising edge t+2.
- Capture rules:
  - Every dv beat in IDLE/COLLECT counts toward N, regardless of index order. Natural and bit-reversed order are both accepted.
  - Beats with xk_index >= KEEP_BINS count toward N but are not written.
  - Duplicate indices: last write wins.
  - dv may be continuous (one beat per cycle) or gapped.
- Frame complete: the stage-2 write of the N-th beat. DRAIN is entered on the next cycle.
- Drain:
  - Buffer read is synchronous (1-cycle).
  - pwr_valid rises 2 cycles after frame complete with bin 0.
  - Bins are presented 0..KEEP_BINS-1 in order.
  - While pwr_valid=1 and pwr_ready=0, pwr_data, pwr_bin and pwr_last are held stable.
  - Throughput is one bin per cycle when pwr_ready is held high (read-ahead prefetch).
  - pwr_last=1 only with bin KEEP_BINS-1. pwr_valid drops the cycle after that handshake.
- Overrun:
  - dv during DRAIN: the beat is dropped, ovf is set, and the drain continues unaffected.
  - ovf_clr clears ovf; set has priority if both occur in the same cycle.
- busy: 1 in COLLECT and DRAIN, 0 in IDLE.
- No synchronous abort: the only way to cancel mid-frame is rst_n. After reset, a partial frame is discarded and the next dv starts a new frame.

Optional Feature:
- Macro: FRAME_ENERGY_EN.
- Defined:
  - Adds output port frame_energy [PWR_W+NFFT_LOG2-1:0], the sum of the stored powers of bins 0..KEEP_BINS-1 for the frame. It is accumulated at stage-2 write time.
  - Adds output port frame_energy_valid, a 1-cycle pulse at frame complete.
  - The accumulator clears on entry to COLLECT. With duplicate indices, every written beat is accumulated.
- Undefined: the ports and accumulator are absent and all other behaviour is identical.

Test Plan:
- Single tone:
  - Stimulus: 512 consecutive dv beats, index 0..511; xk_re=32768 (2^15) at bin 3, all other re/im 0; pwr_ready=1.
  - Required: 257 output beats; bin 3 pwr_data=1, all others 0; pwr_last only on bin 256; busy falls after last.
- Sign/width extremes:
  - Stimulus: bin 0 re=-(2^39), im=-(2^39).
  - Required: pwr_data=2^49; no saturation.
  - Stimulus: bin 1 re=2^20, im=0.
  - Required: pwr_data=1024.
- Bit-reversed order with gapped dv:
  - Stimulus: dv toggling every other cycle, bin k carries re=k<<15.
  - Required: output bin k = k*k for k=0..256, in order 0..256.
- Backpressure:
  - Stimulus: pwr_ready random 50%.
  - Required: data stable while stalled; no bins lost or duplicated; exactly 257 handshakes.
- Overrun and reset:
  - Stimulus: dv asserted during DRAIN.
  - Required: ovf=1; drained data unchanged; ovf_clr→ovf=0.
  - Stimulus: rst_n pulsed after 100 beats of a frame.
  - Required: outputs return to reset values; the following full frame drains correctly.
- FRAME_ENERGY_EN:
  - Stimulus: tone at bins 3 and 300, each re=2^15.
  - Required: frame_energy=1 (bin 300 excluded); a single frame_energy_valid pulse.

Source files
------------

// File: rtl/fft_power_collector.sv
// rtl/fft_power_collector.sv - FFT bin power collector: square/sum, half-spectrum frame buffer, in-order drain
// Optional build macro FRAME_ENERGY_EN adds frame_energy / frame_energy_valid outputs.
module fft_power_collector #(
  parameter int NFFT_LOG2 = 9,
  parameter int XK_W      = 40,
  parameter int PWR_SHIFT = 30,
  parameter int PWR_W     = 64,
  parameter int KEEP_BINS = 257
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        dv,
  input  logic [NFFT_LOG2-1:0]        xk_index,
  input  logic signed [XK_W-1:0]      xk_re,
  input  logic signed [XK_W-1:0]      xk_im,
  input  logic                        ovf_clr,
  output logic                        pwr_valid,
  input  logic                        pwr_ready,
  output logic [PWR_W-1:0]            pwr_data,
  output logic [NFFT_LOG2-1:0]        pwr_bin,
  output logic                        pwr_last,
  output logic                        busy,
  output logic                        ovf
`ifdef FRAME_ENERGY_EN
  ,
  output logic [PWR_W+NFFT_LOG2-1:0]  frame_energy,
  output logic                        frame_energy_valid
`endif
);

  localparam int N      = 1 << NFFT_LOG2;
  localparam int CW     = NFFT_LOG2 + 1;
  localparam int PROD_W = 2 * XK_W;
  localparam int SUM_W  = PROD_W + 1;

  localparam logic [CW-1:0]        LAST_BEAT = CW'(N - 1);
  localparam logic [CW-1:0]        FULL_CNT  = CW'(N);
  localparam logic [CW-1:0]        KEEP_CNT  = CW'(KEEP_BINS);
  localparam logic [NFFT_LOG2-1:0] LAST_BIN  = NFFT_LOG2'(KEEP_BINS - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t                    state;
  logic [CW-1:0]             beat_cnt;

  // stage 1 of the power pipeline
  logic                      s1_valid;
  logic                      s1_last;
  logic [NFFT_LOG2-1:0]      s1_idx;
  logic signed [PROD_W-1:0]  s1_re2;
  logic signed [PROD_W-1:0]  s1_im2;

  // stage 2 (combinational, written into the buffer at the next edge)
  logic signed [PROD_W-1:0]  re_x;
  logic signed [PROD_W-1:0]  im_x;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   shifted;
  logic [PWR_W-1:0]          pwr_next;

  // frame buffer and drain side
  logic [PWR_W-1:0]          mem [0:KEEP_BINS-1];
  logic [PWR_W-1:0]          rd_data;
  logic [NFFT_LOG2-1:0]      rd_bin;
  logic                      rd_full;
  logic [CW-1:0]             rd_ptr;

  logic                      accept;
  logic                      wr_en;
  logic                      frame_done;
  logic                      out_take;
  logic                      rd_en;

  // A beat is taken only while a frame is being collected and not yet full;
  // anything else (DRAIN, or the short wait for the last write) is an overrun.
  assign accept     = dv && (state != DRAIN) && (beat_cnt != FULL_CNT);
  assign wr_en      = s1_valid && ({1'b0, s1_idx} < KEEP_CNT);
  assign frame_done = s1_valid && s1_last;

  assign re_x    = PROD_W'(xk_re);
  assign im_x    = PROD_W'(xk_im);
  assign sum     = SUM_W'(s1_re2) + SUM_W'(s1_im2);
  assign shifted = sum >>> PWR_SHIFT;

  generate
    if (SUM_W > PWR_W) begin : g_sat
      assign pwr_next = (|shifted[SUM_W-1:PWR_W]) ? {PWR_W{1'b1}} : shifted[PWR_W-1:0];
    end else begin : g_nosat
      assign pwr_next = PWR_W'(shifted);
    end
  endgenerate

  // Read stage hands its word to the output register when that register is empty or being consumed.
  assign out_take = rd_full && (!pwr_valid || pwr_ready);
  // Prefetch the next bin whenever the read stage is empty or emptying this cycle.
  assign rd_en    = (state == DRAIN) && (rd_ptr < KEEP_CNT) && (!rd_full || out_take);

  // Frame FSM: beat counting, state sequencing and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      if (accept) begin
        beat_cnt <= beat_cnt + CW'(1);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state <= COLLECT;
            busy  <= 1'b1;
          end
        end
        COLLECT: begin
          if (frame_done) begin
            state    <= DRAIN;
            beat_cnt <= '0;
          end
        end
        DRAIN: begin
          if (pwr_valid && pwr_ready && pwr_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: register squares, index and the "N-th beat" marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_idx   <= '0;
      s1_re2   <= '0;
      s1_im2   <= '0;
    end else begin
      s1_valid <= accept;
      s1_last  <= accept && (beat_cnt == LAST_BEAT);
      if (accept) begin
        s1_idx <= xk_index;
        s1_re2 <= re_x * re_x;
        s1_im2 <= im_x * im_x;
      end
    end
  end

  // Frame buffer: stage-2 write port and synchronous read port (contents not reset).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[s1_idx] <= pwr_next;
    end
    if (rd_en) begin
      rd_data <= mem[rd_ptr[NFFT_LOG2-1:0]];
    end
  end

  // Drain read pointer and read-stage occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      rd_full <= 1'b0;
      rd_bin  <= '0;
    end else if (frame_done) begin
      rd_ptr  <= '0;
      rd_full <= 1'b0;
    end else if (rd_en) begin
      rd_ptr  <= rd_ptr + CW'(1);
      rd_full <= 1'b1;
      rd_bin  <= rd_ptr[NFFT_LOG2-1:0];
    end else if (out_take) begin
      rd_full <= 1'b0;
    end
  end

  // Output register: loads from the read stage, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_valid <= 1'b0;
      pwr_data  <= '0;
      pwr_bin   <= '0;
      pwr_last  <= 1'b0;
    end else if (out_take) begin
      pwr_valid <= 1'b1;
      pwr_data  <= rd_data;
      pwr_bin   <= rd_bin;
      pwr_last  <= (rd_bin == LAST_BIN);
    end else if (pwr_valid && pwr_ready) begin
      pwr_valid <= 1'b0;
      pwr_last  <= 1'b0;
    end
  end

  // Sticky overrun flag; a new overrun wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (dv && !accept) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

`ifdef FRAME_ENERGY_EN
  logic [PWR_W+NFFT_LOG2-1:0] energy_acc;

  // Energy accumulator: cleared when a frame starts, adds every written beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      energy_acc         <= '0;
      frame_energy_valid <= 1'b0;
    end else begin
      frame_energy_valid <= frame_done;
      if ((state == IDLE) && accept) begin
        energy_acc <= '0;
      end else if (wr_en) begin
        energy_acc <= energy_acc + (PWR_W+NFFT_LOG2)'(pwr_next);
      end
    end
  end

  assign frame_energy = energy_acc;
`endif

endmodule

// File: tb/tb_fft_power_collector.sv
// tb/tb_fft_power_collector.sv - self-checking bench for fft_power_collector
module tb_fft_power_collector;

  localparam int NL = 9;
  localparam int XW = 40;
  localparam int PS = 30;
  localparam int PW = 64;
  localparam int KB = 257;
  localparam int N  = 512;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 dv;
  logic [NL-1:0]        xk_index;
  logic signed [XW-1:0] xk_re;
  logic signed [XW-1:0] xk_im;
  logic                 ovf_clr;
  logic                 pwr_valid;
  logic                 pwr_ready;
  logic [PW-1:0]        pwr_data;
  logic [NL-1:0]        pwr_bin;
  logic                 pwr_last;
  logic                 busy;
  logic                 ovf;
`ifdef FRAME_ENERGY_EN
  logic [PW+NL-1:0]     frame_energy;
  logic                 frame_energy_valid;
  int                   fe_pulses;
  logic [PW+NL-1:0]     fe_value;
`endif

  fft_power_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dv        (dv),
    .xk_index  (xk_index),
    .xk_re     (xk_re),
    .xk_im     (xk_im),
    .ovf_clr   (ovf_clr),
    .pwr_valid (pwr_valid),
    .pwr_ready (pwr_ready),
    .pwr_data  (pwr_data),
    .pwr_bin   (pwr_bin),
    .pwr_last  (pwr_last),
    .busy      (busy),
    .ovf       (ovf)
`ifdef FRAME_ENERGY_EN
    ,
    .frame_energy       (frame_energy),
    .frame_energy_valid (frame_energy_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NL-1:0] bin;
    logic [PW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct {
    int                   bin;
    logic signed [XW-1:0] re;
    logic signed [XW-1:0] im;
    logic [PW-1:0]        pwr;
  } vec_t;

  exp_t                 sb[$];
  exp_t                 mon_e;
  int                   checks = 0;
  int                   failures = 0;
  int                   ready_mode = 1;
  int                   hs_cnt = 0;
  logic signed [XW-1:0] fre[N];
  logic signed [XW-1:0] fim[N];
  int                   fidx[N];
  logic [PW-1:0]        mbuf[KB];
  logic                 prev_stall = 1'b0;
  logic [PW+NL:0]       prev_out;
  vec_t                 tbl[9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, want);
    end
  endtask

  function automatic logic [PW-1:0] model_pwr(input logic signed [XW-1:0] re, input logic signed [XW-1:0] im);
    logic signed [127:0] r;
    logic signed [127:0] i;
    logic signed [127:0] s;
    r = re;
    i = im;
    s = (r * r + i * i) >>> PS;
    if (s[127:PW] != 0) return {PW{1'b1}};
    return s[PW-1:0];
  endfunction

  function automatic int bitrev(input int v);
    int r = 0;
    for (int b = 0; b < NL; b++) r |= ((v >> b) & 1) << (NL - 1 - b);
    return r;
  endfunction

  task automatic fill_zero();
    for (int i = 0; i < N; i++) begin
      fidx[i] = i;
      fre[i]  = '0;
      fim[i]  = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      dv       = 1'b1;
      xk_index = NL'(fidx[i]);
      xk_re    = fre[i];
      xk_im    = fim[i];
      if (fidx[i] < KB) mbuf[fidx[i]] = model_pwr(fre[i], fim[i]);
      tick();
      dv = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int k = 0; k < KB; k++) begin
      e.bin  = NL'(k);
      e.data = mbuf[k];
      e.last = (k == KB - 1);
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((busy || sb.size() != 0) && cyc < 5000) begin
      tick();
      cyc++;
    end
    check({name, "_drain_done"}, {busy, sb.size() == 0}, {1'b0, 1'b1});
    check({name, "_handshakes"}, hs_cnt, KB);
    tick();
    check({name, "_valid_low"}, {pwr_valid, pwr_last}, 2'b00);
    sb.delete();
  endtask

  // Pull-side driver for pwr_ready: 0 = held low, 1 = held high, 2 = random.
  initial begin
    pwr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       pwr_ready = 1'b0;
        1:       pwr_ready = 1'b1;
        default: pwr_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard pop on each handshake, hold check while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) check("stall_hold", {pwr_valid, pwr_last, pwr_bin, pwr_data}, {1'b1, prev_out});
      if (pwr_valid && pwr_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual_bin=%0d expected=none", pwr_bin);
        end else begin
          mon_e = sb.pop_front();
          check("beat", {pwr_last, pwr_bin, pwr_data}, {mon_e.last, mon_e.bin, mon_e.data});
        end
      end
      prev_stall = pwr_valid && !pwr_ready;
      prev_out   = {pwr_last, pwr_bin, pwr_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

`ifdef FRAME_ENERGY_EN
  always @(negedge clk) begin
    if (rst_n && frame_energy_valid) begin
      fe_pulses++;
      fe_value = frame_energy;
    end
  end
`endif

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int lat;
    int cyc;

    tbl[0] = '{0,   40'sh80_0000_0000, 40'sh80_0000_0000, 64'h0002_0000_0000_0000};
    tbl[1] = '{1,   40'sd1048576,      40'sd0,            64'd1024};
    tbl[2] = '{2,   40'sd32768,        40'sd0,            64'd1};
    tbl[3] = '{3,   40'sd0,            -40'sd32768,       64'd1};
    tbl[4] = '{4,   40'sd32767,        40'sd0,            64'd0};
    tbl[5] = '{5,   40'sd46341,        40'sd0,            64'd2};
    tbl[6] = '{6,   40'sh7F_FFFF_FFFF, 40'sh7F_FFFF_FFFF, 64'h0001_FFFF_FFFF_F800};
    tbl[7] = '{7,   40'sh80_0000_0000, 40'sd0,            64'h0001_0000_0000_0000};
    tbl[8] = '{256, 40'sd98304,        40'sd131072,       64'd25};

    rst_n    = 1'b0;
    dv       = 1'b0;
    xk_index = '0;
    xk_re    = '0;
    xk_im    = '0;
    ovf_clr  = 1'b0;
`ifdef FRAME_ENERGY_EN
    fe_pulses = 0;
    fe_value  = '0;
`endif
    repeat (3) tick();
    check("reset_outputs", {pwr_valid, pwr_data, pwr_bin, pwr_last, busy, ovf}, '0);
    rst_n = 1'b1;
    tick();

    // Single tone at bin 3, natural order, continuous dv
    fill_zero();
    fre[3] = 40'sd32768;
    hs_cnt = 0;
    send_beats(N, 0);
    check("tone_busy", busy, 1'b1);
    push_expected();
    lat = 0;
    while (!pwr_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("tone_first_valid_latency", lat, 4);
    wait_drain("tone");

    // Sign and width extremes from the vector table
    fill_zero();
    for (int v = 0; v < 9; v++) begin
      fre[tbl[v].bin] = tbl[v].re;
      fim[tbl[v].bin] = tbl[v].im;
    end
    fre[300] = 40'sh7F_FFFF_FFFF;
    hs_cnt = 0;
    send_beats(N, 0);
    for (int v = 0; v < 9; v++) mbuf[tbl[v].bin] = tbl[v].pwr;
    push_expected();
    wait_drain("extremes");

    // Bit-reversed order, dv every other cycle, bin k carries k<<15
    for (int i = 0; i < N; i++) begin
      fidx[i] = bitrev(i);
      fre[i]  = XW'(fidx[i]) <<< 15;
      fim[i]  = '0;
    end
    hs_cnt = 0;
    send_beats(N, 1);
    for (int k = 0; k < KB; k++) mbuf[k] = PW'(k * k);
    push_expected();
    wait_drain("bitrev");

    // Random data with duplicate indices under random backpressure
    for (int i = 0; i < N; i++) begin
      fidx[i] = (i < 256) ? i : i - 255;
      fre[i]  = XW'({$urandom, $urandom});
      fim[i]  = XW'({$urandom, $urandom});
    end
    ready_mode = 2;
    hs_cnt = 0;
    send_beats(N, 0);
    push_expected();
    wait_drain("backpressure");

    // Overrun: dv while draining with the sink stalled
    for (int i = 0; i < N; i++) begin
      fidx[i] = i;
      fre[i]  = XW'({$urandom, $urandom});
      fim[i]  = XW'($urandom);
    end
    ready_mode = 0;
    hs_cnt = 0;
    send_beats(N, 0);
    push_expected();
    cyc = 0;
    while (!pwr_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check("overrun_valid_seen", pwr_valid, 1'b1);
    check("ovf_clear_before", ovf, 1'b0);
    for (int i = 0; i < 3; i++) begin
      dv       = 1'b1;
      xk_index = NL'(i);
      xk_re    = XW'({$urandom, $urandom});
      xk_im    = '0;
      tick();
    end
    dv = 1'b0;
    check("ovf_set", ovf, 1'b1);
    dv      = 1'b1;
    ovf_clr = 1'b1;
    tick();
    dv      = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_set_priority", ovf, 1'b1);
    ready_mode = 2;
    wait_drain("overrun");
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", ovf, 1'b0);
    ready_mode = 1;
    tick();

    // Reset in the middle of a frame, then a full frame
    for (int i = 0; i < N; i++) begin
      fidx[i] = i;
      fre[i]  = XW'($urandom);
      fim[i]  = XW'($urandom);
    end
    send_beats(100, 0);
    check("partial_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", {pwr_valid, pwr_data, pwr_bin, pwr_last, busy, ovf}, '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      fre[i] = XW'({$urandom, $urandom});
      fim[i] = XW'({$urandom, $urandom});
    end
    hs_cnt = 0;
    send_beats(N, 0);
    push_expected();
    wait_drain("after_reset");

`ifdef FRAME_ENERGY_EN
    // Frame energy: tones at bins 3 and 300, only bin 3 is kept
    fill_zero();
    fre[3]   = 40'sd32768;
    fre[300] = 40'sd32768;
    fe_pulses = 0;
    hs_cnt = 0;
    send_beats(N, 0);
    push_expected();
    wait_drain("energy");
    check("energy_pulses", fe_pulses, 1);
    check("energy_value", fe_value, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
